// File: rtl/debug_slave_sysclk_cmdq.sv
// System-clock half of the JTAG debug slave: synchronises TCK-domain update strobes,
// queues the captured snapshots, and decodes popped commands into action strobes.
module debug_slave_sysclk_cmdq #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACTION_BIT  = 34
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [DATA_W-1:0]             sr,
    input  logic                          vs_udr,
    input  logic                          vs_uir,
    input  logic                          cmd_ready,
    input  logic                          clear_overflow,
    output logic                          cmd_valid,
    output logic [IR_W-1:0]               cmd_ir,
    output logic                          cmd_is_dr,
    output logic [DATA_W-1:0]             jdo,
    output logic [(1<<IR_W)-1:0]          take_action,
    output logic [(1<<IR_W)-1:0]          take_no_action,
    output logic                          uir_strobe,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int N_ACT    = 1 << IR_W;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int LVL_W    = PTR_W + 1;
    localparam int SETTLE_W = SYNC_STAGES + 1;

    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic                   udr_dly;
    logic                   uir_dly;
    logic [SETTLE_W-1:0]    settle;
    logic                   udr_pulse;
    logic                   uir_pulse;

    // settle masks edge detection until the synchronizer and delay flops have
    // been refilled after reset, so a strobe already high at release is not seen as new
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync <= '0;
            uir_sync <= '0;
            udr_dly  <= 1'b0;
            uir_dly  <= 1'b0;
            settle   <= '0;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_dly  <= udr_sync[SYNC_STAGES-1];
            uir_dly  <= uir_sync[SYNC_STAGES-1];
            settle   <= {settle[SETTLE_W-2:0], 1'b1};
        end
    end

    assign udr_pulse = settle[SETTLE_W-1] & udr_sync[SYNC_STAGES-1] & ~udr_dly;
    assign uir_pulse = settle[SETTLE_W-1] & uir_sync[SYNC_STAGES-1] & ~uir_dly;

    logic [IR_W-1:0]   mem_ir   [0:FIFO_DEPTH-1];
    logic [DATA_W-1:0] mem_data [0:FIFO_DEPTH-1];
    logic              mem_dr   [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;

    logic              full;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              overflow_set;
    logic [DATA_W-1:0] push_data;
    logic [IR_W-1:0]   head_ir;
    logic [DATA_W-1:0] head_data;
    logic              head_dr;
    logic [N_ACT-1:0]  act_onehot;

    assign full      = (count == LVL_W'(FIFO_DEPTH));
    assign push_req  = udr_pulse | uir_pulse;
    assign pop       = cmd_valid & cmd_ready;
    assign push_ok   = push_req & (~full | pop);
    assign push_data = udr_pulse ? sr : '0;

    // A simultaneous IR update is always lost because the DR entry takes the slot
    assign overflow_set = (push_req & full & ~pop) | (udr_pulse & uir_pulse);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_ir[wr_ptr]   <= ir_in;
            mem_data[wr_ptr] <= push_data;
            mem_dr[wr_ptr]   <= udr_pulse;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + LVL_W'(push_ok) - LVL_W'(pop);
        end
    end

    assign head_ir    = mem_ir[rd_ptr];
    assign head_data  = mem_data[rd_ptr];
    assign head_dr    = mem_dr[rd_ptr];
    assign act_onehot = N_ACT'(1) << head_ir;

    // Head fields are gated so the outputs read zero while the queue is empty
    assign cmd_valid  = (count != '0);
    assign cmd_ir     = cmd_valid ? head_ir : '0;
    assign cmd_is_dr  = cmd_valid & head_dr;
    assign fifo_level = count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo            <= '0;
            take_action    <= '0;
            take_no_action <= '0;
            uir_strobe     <= 1'b0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            uir_strobe     <= 1'b0;
            if (pop) begin
                if (head_dr) begin
                    jdo <= head_data;
                    if (head_data[ACTION_BIT]) begin
                        take_action <= act_onehot;
                    end else begin
                        take_no_action <= act_onehot;
                    end
                end else begin
                    uir_strobe <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: doc/debug_slave_sysclk_cmdq.md
Name: debug_slave_sysclk_cmdq

Overview:
- System-clock half of the JTAG debug slave, generalised in data width, IR width and synchronizer depth.
- Synchronises the TCK-domain update strobes (vs_udr, vs_uir) into clk and captures the sr/ir_in snapshot on each update.
- Queues the snapshots in a small command FIFO, so back-to-back JTAG updates are no longer lost while the CPU side is busy.
- Pops commands under a valid/ready handshake and decodes each into one-hot take_action / take_no_action strobes, with a persistent jdo.

Parameters:
DATA_W, 38, width of sr and jdo
IR_W, 2, virtual-JTAG IR width; action vectors are 2**IR_W wide
SYNC_STAGES, 2, synchronizer flops per strobe (min 2)
FIFO_DEPTH, 4, command entries (power of 2, min 2)
ACTION_BIT, 34, jdo bit that selects take_action vs take_no_action (< DATA_W)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset; clock named clk, reset named reset_n, as elsewhere in the codebase
ir_in  in  IR_W  TCK-domain IR, stable around update strobes
sr  in  DATA_W  TCK-domain shift register, stable around vs_udr
vs_udr  in  1  TCK-domain update-DR state, asynchronous to clk
vs_uir  in  1  TCK-domain update-IR state, asynchronous to clk
cmd_ready  in  1  consumer accepts head command
clear_overflow  in  1  clears the overflow flag
cmd_valid  out  1  FIFO not empty
cmd_ir  out  IR_W  head command IR
cmd_is_dr  out  1  head is DR update (1) or IR update (0)
jdo  out  DATA_W  data of the last popped DR command, held
take_action  out  2**IR_W  one-cycle one-hot strobe
take_no_action  out  2**IR_W  one-cycle one-hot strobe
uir_strobe  out  1  one-cycle strobe when an IR command is popped
overflow  out  1  sticky; an update was dropped
fifo_level  out  clog2(FIFO_DEPTH)+1  entry count

Behaviour:
- Reset: all outputs 0, synchronizers cleared, FIFO flushed. Applies asynchronously, including mid-operation; in-flight strobes are discarded.
- Synchronizer: vs_udr and vs_uir each pass through SYNC_STAGES flops, then one delay flop for edge detection.
  - A rising edge produces a 1-cycle internal pulse. Level-high inputs produce no further pulses.
- Push on a udr pulse: entry {ir_in, sr, is_dr=1}, with ir_in/sr sampled on that clk edge.
- Push on a uir pulse: entry {ir_in, data=0, is_dr=0}.
- Same-cycle udr and uir pulses: the udr entry is pushed, the uir event is dropped and overflow is set.
- Latency: vs_udr rises before edge k; push at edge k+SYNC_STAGES; cmd_valid is high after that edge.
- FWFT FIFO: cmd_ir and cmd_is_dr always reflect the head entry. Pop occurs when cmd_valid && cmd_ready.
- Full: a push while full with no pop is dropped and overflow is set. A push while full with a same-cycle pop is accepted, and fifo_level stays at FIFO_DEPTH.
- Empty: cmd_ready is ignored and nothing changes.
- Pop of a DR entry, registered and visible after the pop edge:
  - jdo is loaded with the entry data.
  - take_action[ir] = 1 if data[ACTION_BIT], else take_no_action[ir] = 1.
  - All other strobe bits are 0. Strobes last exactly 1 cycle.
- Pop of an IR entry: uir_strobe = 1 for 1 cycle; jdo is unchanged; no action strobes.
- jdo holds its value between DR pops.
- overflow:
  - Cleared by clear_overflow.
  - If a set event and clear_overflow coincide, set wins.
- fifo_level updates on the same edge as the push/pop.

Test Plan:
- Single DR update, SYNC_STAGES=2, cmd_ready=1: sr=38'h04_0000_1234 (bit34=1), ir_in=2, vs_udr held high 10 cycles -> cmd_valid high 1 cycle. Next cycle: jdo=38'h04_0000_1234, take_action=4'b0100 for exactly 1 cycle, take_no_action=0, no second command.
- ACTION_BIT clear: ir_in=0, sr=38'h00_0000_00FF -> take_no_action=4'b0001 for 1 cycle, take_action=0.
- Backpressure/full: cmd_ready=0, five DR updates with data 1..5 -> fifo_level=4, overflow=1. Then cmd_ready=1 -> jdo sequence 1,2,3,4, fifo_level reaches 0.
- Full with simultaneous push/pop: level 4, push and pop on the same edge -> level stays 4, overflow stays 0, popped entry is the oldest.
- IR update: pulse vs_uir with ir_in=3 -> cmd_is_dr=0, uir_strobe for 1 cycle, jdo unchanged, no action strobes.
- Reset mid-operation: 3 entries queued, assert reset_n=0 asynchronously -> cmd_valid, fifo_level, jdo and overflow all 0 immediately. After release, no spurious pulse while vs_udr is still high.
